// File: rtl/fifo_serializer_if.sv
// FIFO-side bundle for fifo_serializer: occupancy, head word and pop strobe.
// master = FIFO (drives count/data_in), slave = serializer (drives pop).
interface fifo_serializer_if #(
    parameter int Depth = 4,
    parameter int Bits  = 8
);
    localparam int CW = $clog2(Bits + 1);

    logic [CW-1:0]    count;
    logic [Depth-1:0] data_in;
    logic             pop;

    modport master (output count, output data_in, input pop);
    modport slave  (input count, input data_in, output pop);
endinterface

// File: rtl/fifo_serializer.sv
// FIFO drain stage: pops one word at a time and sends it as a start/data(LSB first)/stop frame.
// Optional even-parity bit before STOP when FIFO_SER_PARITY_EN is defined.
module fifo_serializer #(
    parameter int Depth = 4,
    parameter int Bits  = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    fifo_serializer_if.slave fifo,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);
    localparam int CW = $clog2(Bits + 1);
    localparam int BW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int NW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
    localparam logic [NW-1:0] BIT_LAST  = NW'(Depth - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

    state_t           state, state_next;
    logic [BW-1:0]    baud;
    logic [NW-1:0]    bit_cnt;
    logic [Depth-1:0] shreg;
    logic [CW-1:0]    occ;
    logic             baud_end;

    assign occ      = fifo.count;
    assign baud_end = (baud == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (en && occ != '0) state_next = LOAD;
            LOAD:  state_next = START;
            START: if (baud_end) state_next = DATA;
            DATA: begin
                if (baud_end && bit_cnt == BIT_LAST) begin
`ifdef FIFO_SER_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef FIFO_SER_PARITY_EN
            PARITY: if (baud_end) state_next = STOP;
`endif
            STOP:  if (baud_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Baud counter restarts on every state entry and at each bit boundary in DATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud    <= '0;
            bit_cnt <= '0;
        end else begin
            if (state == IDLE || state_next != state || baud_end) baud <= '0;
            else                                                 baud <= baud + 1'b1;

            if (state != DATA)  bit_cnt <= '0;
            else if (baud_end)  bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Head word is captured on the edge that ends LOAD, the same edge the FIFO pops on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       shreg <= '0;
        else if (state == LOAD)           shreg <= fifo.data_in;
        else if (state == DATA && baud_end) shreg <= shreg >> 1;
    end

`ifdef FIFO_SER_PARITY_EN
    logic par;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             par <= 1'b0;
        else if (state == LOAD) par <= ^fifo.data_in;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo.pop <= 1'b0;
            busy     <= 1'b0;
        end else begin
            fifo.pop <= (state_next == LOAD);
            busy     <= (state_next != IDLE);
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            START:  tx = 1'b0;
            DATA:   tx = shreg[0];
`ifdef FIFO_SER_PARITY_EN
            PARITY: tx = par;
`endif
            default: tx = 1'b1;
        endcase
    end

    assign frame_done = (state == STOP) && baud_end;
endmodule

// File: tb/tb_fifo_serializer.sv
// Directed bench for fifo_serializer (Depth=4, DIV=4) with a small queue standing in for the FIFO.
module tb_fifo_serializer;
    localparam int DIV = 4;
`ifdef FIFO_SER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NBITS  = 6 + P;
    localparam int FL     = DIV * NBITS;
    localparam int PERIOD = 2 + FL;

    logic clk, rst_n, en, tx, busy, frame_done;
    int   n_cmp, n_err, cyc, pop_total;
    logic [3:0] q[$];
    logic pend;

    fifo_serializer_if #(.Depth(4), .Bits(8)) fif ();

    fifo_serializer #(.Depth(4), .Bits(8), .DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .fifo       (fif),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // FIFO stand-in: the head leaves one negedge after the pop cycle, i.e. after the capture edge.
    always @(negedge clk) begin
        if (pend && q.size() > 0) void'(q.pop_front());
        pend = 1'b0;
        if (fif.pop === 1'b1) begin
            pend = 1'b1;
            pop_total++;
        end
        fif.count   = 4'(q.size());
        fif.data_in = (q.size() > 0) ? q[0] : 4'h0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] w);
        #1 q.push_back(w);
    endtask

    function automatic logic exp_tx(input logic [3:0] w, input int k);
        int b;
        b = (k - 1) / DIV;
        if (b == 0)           return 1'b0;
        if (b <= 4)           return w[b-1];
        if (P == 1 && b == 5) return ^w;
        return 1'b1;
    endfunction

    task automatic wait_pop(input string tag, output bit found);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fif.pop === 1'b1) begin
                found = 1;
                break;
            end
        end
        check({tag, "_pop_seen"}, 32'(found), 32'd1);
    endtask

    // k=0 is the pop (LOAD) cycle; k=1..FL covers START..STOP; k=FL+1 must be IDLE.
    task automatic run_frame(input logic [3:0] w, input string tag, input int drop_k, output int pcyc);
        bit found;
        int busy_n, done_n, done_k, pops;
        pcyc = 0;
        wait_pop(tag, found);
        if (!found) return;
        pcyc   = cyc;
        busy_n = (busy === 1'b1) ? 1 : 0;
        done_n = 0;
        done_k = -1;
        pops   = 1;
        for (int k = 1; k <= FL; k++) begin
            @(negedge clk);
            check($sformatf("%s_tx_k%0d", tag, k), 32'(tx), 32'(exp_tx(w, k)));
            if (busy === 1'b1) busy_n++;
            if (frame_done === 1'b1) begin
                done_n++;
                done_k = k;
            end
            if (fif.pop === 1'b1) pops++;
            if (k == drop_k) en = 1'b0;
        end
        @(negedge clk);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check({tag, "_tx_idle"}, 32'(tx), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(FL + 1));
        check({tag, "_pop_width"}, 32'(pops), 32'd1);
        check({tag, "_done_count"}, 32'(done_n), 32'd1);
        check({tag, "_done_pos"}, 32'(done_k), 32'(FL));
    endtask

    initial begin
        int p0, p1, p2;
        bit found;
        n_cmp = 0; n_err = 0; cyc = 0; pop_total = 0; pend = 1'b0;
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_pop", 32'(fif.pop), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;

        // Empty FIFO with en high: nothing may happen.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_tx", 32'(tx), 32'd1);
            check("idle_pop", 32'(fif.pop), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end

        push(4'b1011);
        run_frame(4'b1011, "single", -1, p0);
        repeat (5) @(negedge clk);
        check("single_pop_total", 32'(pop_total), 32'd1);

        push(4'h1); push(4'h2); push(4'hF);
        run_frame(4'h1, "burst0", -1, p0);
        run_frame(4'h2, "burst1", -1, p1);
        run_frame(4'hF, "burst2", -1, p2);
        check("burst_gap01", 32'(p1 - p0), 32'(PERIOD));
        check("burst_gap12", 32'(p2 - p1), 32'(PERIOD));
        repeat (40) @(negedge clk);
        check("burst_no_4th", 32'(pop_total), 32'd4);

        push(4'h5); push(4'hA);
        run_frame(4'h5, "gate", 5, p0);
        repeat (60) @(negedge clk);
        check("gate_pop_total", 32'(pop_total), 32'd5);
        check("gate_count_left", 32'(fif.count), 32'd1);
        en = 1'b1;
        run_frame(4'hA, "regate", -1, p0);
        check("regate_pop_total", 32'(pop_total), 32'd6);

        push(4'h0);
        wait_pop("midrst", found);
        repeat (4 * DIV - 2) @(negedge clk);
        check("midrst_tx_before", 32'(tx), 32'd0);
        check("midrst_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_pop", 32'(fif.pop), 32'd0);
        repeat (2) @(negedge clk);
        check("midrst_pop_total", 32'(pop_total), 32'd7);
        rst_n = 1'b1;
        push(4'h6);
        run_frame(4'h6, "postrst", -1, p0);
        check("postrst_pop_total", 32'(pop_total), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
